// File: rtl/synth_pkg.sv
// Shared constants and FSM state type for the keyboard voice allocator.
package synth_pkg;

   localparam int NUM_KEYS  = 13;
   localparam int NOTE_W    = 4;
   localparam int KEY_IDX_W = 4;
   localparam logic [KEY_IDX_W-1:0] LAST_KEY = KEY_IDX_W'(NUM_KEYS - 1);

   typedef enum logic {
      IDLE = 1'b0,
      SCAN = 1'b1
   } alloc_state_t;

endpackage

// File: rtl/voice_pick.sv
// Combinational voice chooser: lowest-index free voice and oldest gated voice
// (maximum age, lowest index wins a tie).
module voice_pick #(
   parameter int NUM_VOICES = 4,
   parameter int AGE_W      = 4,
   parameter int IDX_W      = 2
) (
   input  logic [NUM_VOICES-1:0]       gate,
   input  logic [NUM_VOICES*AGE_W-1:0] age,
   output logic                        free_found,
   output logic [IDX_W-1:0]            free_idx,
   output logic [IDX_W-1:0]            oldest_idx
);

   logic [AGE_W-1:0] best_age;

   always_comb begin
      free_found = 1'b0;
      free_idx   = '0;
      oldest_idx = '0;
      best_age   = age[AGE_W-1:0];
      // Walking downwards leaves the lowest free index as the final winner.
      for (int v = NUM_VOICES - 1; v >= 0; v--) begin
         if (!gate[v]) begin
            free_found = 1'b1;
            free_idx   = IDX_W'(v);
         end
      end
      for (int v = 1; v < NUM_VOICES; v++) begin
         if (age[v*AGE_W +: AGE_W] > best_age) begin
            best_age   = age[v*AGE_W +: AGE_W];
            oldest_idx = IDX_W'(v);
         end
      end
   end

endmodule

// File: rtl/voice_alloc.sv
// Polyphonic voice allocator: scans one key per cycle and maps note-on/off to voices.
// Define VOICE_STEAL_EN to steal the oldest voice when none is free (otherwise the note is dropped).
module voice_alloc
   import synth_pkg::*;
#(
   parameter int NUM_VOICES = 4,
   parameter int AGE_W      = 4
) (
   input  logic                         clk,
   input  logic                         ar,
   input  logic [NUM_KEYS-1:0]          keys_in,
   output logic [NOTE_W*NUM_VOICES-1:0] voice_note,
   output logic [NUM_VOICES-1:0]        voice_gate,
   output logic [NUM_VOICES-1:0]        voice_trig,
   output logic                         busy,
   output logic                         dropped
);

   localparam int IDX_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
   localparam logic [AGE_W-1:0] AGE_MAX = '1;

   alloc_state_t state, state_n;

   logic [NUM_KEYS-1:0]  sync1, keys_s, keys_prev, keys_snap;
   logic [KEY_IDX_W-1:0] idx;
   logic [NOTE_W-1:0]    note_q [NUM_VOICES];
   logic [AGE_W-1:0]     age_q  [NUM_VOICES];
   logic [NUM_VOICES*AGE_W-1:0] age_flat;

   logic             note_on, note_off;
   logic             free_found;
   logic [IDX_W-1:0] free_idx, oldest_idx, target;
   logic             assign_en, drop_now;

   for (genvar v = 0; v < NUM_VOICES; v++) begin : g_flat
      assign voice_note[v*NOTE_W +: NOTE_W] = note_q[v];
      assign age_flat[v*AGE_W +: AGE_W]     = age_q[v];
   end

   voice_pick #(
      .NUM_VOICES(NUM_VOICES),
      .AGE_W     (AGE_W),
      .IDX_W     (IDX_W)
   ) u_pick (
      .gate      (voice_gate),
      .age       (age_flat),
      .free_found(free_found),
      .free_idx  (free_idx),
      .oldest_idx(oldest_idx)
   );

   always_ff @(posedge clk or negedge ar) begin
      if (!ar) state <= IDLE;
      else     state <= state_n;
   end

   always_comb begin
      state_n = state;
      case (state)
         IDLE:    if (keys_s != keys_prev) state_n = SCAN;
         SCAN:    if (idx == LAST_KEY) state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   assign busy     = (state == SCAN);
   assign note_on  = busy &&  keys_snap[idx] && !keys_prev[idx];
   assign note_off = busy && !keys_snap[idx] &&  keys_prev[idx];

   always_comb begin
      assign_en = 1'b0;
      drop_now  = 1'b0;
      target    = free_idx;
      if (note_on) begin
         if (free_found) begin
            assign_en = 1'b1;
         end else begin
`ifdef VOICE_STEAL_EN
            assign_en = 1'b1;
            target    = oldest_idx;
`else
            drop_now  = 1'b1;
`endif
         end
      end
   end

`ifndef VOICE_STEAL_EN
   logic unused_oldest;
   assign unused_oldest = ^oldest_idx;
`endif

   // A key that is dropped still updates keys_prev, so it is never retried.
   always_ff @(posedge clk or negedge ar) begin
      if (!ar) begin
         sync1      <= '0;
         keys_s     <= '0;
         keys_prev  <= '0;
         keys_snap  <= '0;
         idx        <= '0;
         voice_gate <= '0;
         voice_trig <= '0;
         dropped    <= 1'b0;
         for (int v = 0; v < NUM_VOICES; v++) begin
            note_q[v] <= '0;
            age_q[v]  <= '0;
         end
      end else begin
         sync1      <= keys_in;
         keys_s     <= sync1;
         voice_trig <= '0;
         dropped    <= drop_now;
         if (state == IDLE) begin
            if (keys_s != keys_prev) begin
               keys_snap <= keys_s;
               idx       <= '0;
            end
         end else begin
            keys_prev[idx] <= keys_snap[idx];
            idx            <= idx + 4'd1;
         end
         for (int v = 0; v < NUM_VOICES; v++) begin
            if (assign_en && target == IDX_W'(v)) begin
               note_q[v]     <= NOTE_W'(idx);
               voice_gate[v] <= 1'b1;
               age_q[v]      <= '0;
               voice_trig[v] <= 1'b1;
            end else if (assign_en && voice_gate[v] && age_q[v] != AGE_MAX) begin
               age_q[v] <= age_q[v] + 1'b1;
            end
            if (note_off && voice_gate[v] && note_q[v] == NOTE_W'(idx)) begin
               voice_gate[v] <= 1'b0;
            end
         end
      end
   end

endmodule

// File: tb/tb_voice_alloc.sv
// Directed self-checking bench for voice_alloc (NUM_VOICES=4); expectations follow VOICE_STEAL_EN.
module tb_voice_alloc;

   logic        clk = 1'b0;
   logic        ar  = 1'b1;
   logic [12:0] keys_in = '0;
   logic [15:0] voice_note;
   logic [3:0]  voice_gate;
   logic [3:0]  voice_trig;
   logic        busy;
   logic        dropped;

   int checkCount = 0;
   int passCount  = 0;
   int trigCnt [4];
   int busyCnt;
   int dropCnt;

   voice_alloc #(
      .NUM_VOICES(4),
      .AGE_W     (4)
   ) dut (
      .clk       (clk),
      .ar        (ar),
      .keys_in   (keys_in),
      .voice_note(voice_note),
      .voice_gate(voice_gate),
      .voice_trig(voice_trig),
      .busy      (busy),
      .dropped   (dropped)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checkCount++;
      if (obs === exp) passCount++;
      else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
   endtask

   task automatic clearCounts();
      for (int v = 0; v < 4; v++) trigCnt[v] = 0;
      busyCnt = 0;
      dropCnt = 0;
   endtask

   // Advance n clocks, sampling 1 time unit after each rising edge.
   task automatic runCycles(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
         for (int v = 0; v < 4; v++) trigCnt[v] += int'(voice_trig[v]);
         busyCnt += int'(busy);
         dropCnt += int'(dropped);
      end
   endtask

   task automatic applyStimulus(input logic [12:0] keys, input int n);
      keys_in = keys;
      clearCounts();
      runCycles(n);
   endtask

   initial begin
      clearCounts();
      ar = 1'b0;
      #2;
      checkOutput("rst_gate",  32'(voice_gate), 32'h0);
      checkOutput("rst_note",  32'(voice_note), 32'h0);
      checkOutput("rst_trig",  32'(voice_trig), 32'h0);
      checkOutput("rst_busy",  32'(busy),       32'h0);
      checkOutput("rst_drop",  32'(dropped),    32'h0);
      runCycles(2);
      ar = 1'b1;
      runCycles(1);

      // Single key: gate must rise on the 4th edge after the key changes.
      applyStimulus(13'h0001, 3);
      checkOutput("lat_early_gate", 32'(voice_gate), 32'h0);
      runCycles(1);
      checkOutput("lat_gate",  32'(voice_gate), 32'h1);
      checkOutput("lat_trig",  32'(voice_trig), 32'h1);
      checkOutput("lat_note0", 32'(voice_note[3:0]), 32'h0);
      runCycles(20);
      checkOutput("one_trig_v0", 32'(trigCnt[0]), 32'd1);
      checkOutput("one_busy",    32'(busyCnt),    32'd13);

      // Second key joins on voice 1, then leaves; voice 0 is untouched.
      applyStimulus(13'h0003, 24);
      checkOutput("two_gate",    32'(voice_gate), 32'h3);
      checkOutput("two_note",    32'(voice_note), 32'h0010);
      checkOutput("two_trig_v0", 32'(trigCnt[0]), 32'd0);
      checkOutput("two_trig_v1", 32'(trigCnt[1]), 32'd1);
      applyStimulus(13'h0001, 24);
      checkOutput("off_gate", 32'(voice_gate), 32'h1);
      checkOutput("off_note", 32'(voice_note), 32'h0010);
      checkOutput("off_trig", 32'(trigCnt[0] + trigCnt[1]), 32'd0);

      // Five keys at once on four voices.
      applyStimulus(13'h0000, 24);
      checkOutput("clr1_gate", 32'(voice_gate), 32'h0);
      applyStimulus(13'h001F, 24);
      checkOutput("five_gate", 32'(voice_gate), 32'hF);
`ifdef VOICE_STEAL_EN
      checkOutput("five_note",    32'(voice_note), 32'h3214);
      checkOutput("five_trig_v0", 32'(trigCnt[0]), 32'd2);
      checkOutput("five_drop",    32'(dropCnt),    32'd0);
`else
      checkOutput("five_note",    32'(voice_note), 32'h3210);
      checkOutput("five_trig_v0", 32'(trigCnt[0]), 32'd1);
      checkOutput("five_drop",    32'(dropCnt),    32'd1);
`endif
      checkOutput("five_trig_v3", 32'(trigCnt[3]), 32'd1);

      // Release key 0: stolen note has no owner; unstolen voice 0 goes quiet.
      applyStimulus(13'h001E, 24);
`ifdef VOICE_STEAL_EN
      checkOutput("rel0_gate", 32'(voice_gate), 32'hF);
`else
      checkOutput("rel0_gate", 32'(voice_gate), 32'hE);
`endif
      applyStimulus(13'h000E, 24);
      checkOutput("rel4_gate", 32'(voice_gate), 32'hE);
      checkOutput("rel4_drop", 32'(dropCnt),    32'd0);

      // Key 12 pressed mid-scan (idx=5) is picked up by the following scan.
      applyStimulus(13'h0000, 24);
      checkOutput("clr2_gate", 32'(voice_gate), 32'h0);
      applyStimulus(13'h0001, 8);
      checkOutput("mid_busy", 32'(busy), 32'h1);
      keys_in = 13'h1001;
      runCycles(21);
      checkOutput("mid_gate_early", 32'(voice_gate), 32'h1);
      runCycles(1);
      checkOutput("mid_gate",    32'(voice_gate), 32'h3);
      checkOutput("mid_note",    32'(voice_note[7:0]), 32'hC0);
      runCycles(10);
      checkOutput("mid_trig_v0", 32'(trigCnt[0]), 32'd1);
      checkOutput("mid_trig_v1", 32'(trigCnt[1]), 32'd1);
      checkOutput("mid_busy_n",  32'(busyCnt),    32'd26);

      // Reset in the middle of a scan with four keys held.
      applyStimulus(13'h0000, 24);
      checkOutput("clr3_gate", 32'(voice_gate), 32'h0);
      applyStimulus(13'h1248, 8);
      checkOutput("pre_rst_gate", 32'(voice_gate), 32'h1);
      ar = 1'b0;
      #1;
      checkOutput("arst_gate", 32'(voice_gate), 32'h0);
      checkOutput("arst_note", 32'(voice_note), 32'h0);
      checkOutput("arst_busy", 32'(busy),       32'h0);
      checkOutput("arst_trig", 32'(voice_trig), 32'h0);
      #2;
      ar = 1'b1;
      clearCounts();
      runCycles(24);
      checkOutput("rescan_gate", 32'(voice_gate), 32'hF);
      checkOutput("rescan_note", 32'(voice_note), 32'hC963);
      checkOutput("rescan_trig", 32'(trigCnt[0] + trigCnt[1] + trigCnt[2] + trigCnt[3]), 32'd4);
      checkOutput("rescan_drop", 32'(dropCnt), 32'd0);

      $display("[TB] %0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule

// File: doc/voice_alloc.md
VOICE_ALLOC -- requirements
Module: voice_alloc

Interface
REQ-001 SHALL have parameter NUM_VOICES, default 4, number of synth voices (legal 2..8).
REQ-002 SHALL have parameter AGE_W, default 4, width of each per-voice saturating age counter.
REQ-003 SHALL have port clk  input  1  system clock; all state on rising edge.
REQ-004 SHALL have port ar  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port keys_in  input  13  piano-key held mask, bit n = note n (0=C..12=upper C); asynchronous to clk.
REQ-006 SHALL have port voice_note  output  4*NUM_VOICES  note index per voice, voice v at bits [4v+3:4v].
REQ-007 SHALL have port voice_gate  output  NUM_VOICES  1 = voice sounding.
REQ-008 SHALL have port voice_trig  output  NUM_VOICES  one-cycle pulse when voice gets a new note (restart envelope/phase).
REQ-009 SHALL have port busy  output  1  high while FSM is in SCAN.
REQ-010 SHALL have port dropped  output  1  one-cycle pulse when a note-on is discarded.

Function
REQ-011 SHALL pass keys_in through a 2-flop synchronizer to keys_s before any use.
REQ-012 SHALL hold register keys_prev (13 bits): the key state last processed.
REQ-013 SHALL implement FSM states IDLE and SCAN.
REQ-014 IDLE: if keys_s != keys_prev, latch keys_snap <= keys_s, idx <= 0, go SCAN; else stay.
REQ-015 SCAN: process exactly one key idx per cycle, set keys_prev[idx] <= keys_snap[idx], and increment idx; after idx 12, go IDLE.
REQ-016 Note-on (snap=1, prev=0): assign lowest-index voice with gate=0; set note=idx, gate=1, age=0; pulse trig on that voice the next cycle.
REQ-017 On each note-on, every other gated voice's age SHALL increment, saturating at 2^AGE_W-1.
REQ-018 Note-on with no free voice: behaviour per REQ-027/028.
REQ-019 Note-off (snap=0, prev=1): every gated voice with note==idx SHALL get gate=0; note is retained; no match means no action.
REQ-020 Keys with snap==prev SHALL cause no voice change.
REQ-021 Changes of keys_s during SCAN SHALL be ignored until IDLE, then detected by REQ-014 comparison; no event lost.
REQ-022 Latency: key edge at keys_in -> voice_gate update = 2 (sync) + 1 (IDLE) + idx + 1 cycles; trig aligned with gate rise.
REQ-023 A note SHALL never be assigned to two voices simultaneously.

Reset
REQ-024 On ar low, asynchronously: FSM=IDLE, idx=0, keys_prev=0, keys_snap=0, synchronizer=0.
REQ-025 On ar low: voice_note=0, voice_gate=0, voice_trig=0, ages=0, busy=0, dropped=0.
REQ-026 Reset asserted mid-SCAN SHALL abandon the scan; after release, held keys are re-detected as note-ons from IDLE.

Configuration
REQ-027 With VOICE_STEAL_EN defined: no free voice -> steal voice with maximum age (ties: lowest index); note=idx, age=0, gate stays 1, trig pulses; dropped stays 0.
REQ-028 Without VOICE_STEAL_EN: no free voice -> note discarded, voices unchanged, dropped pulses one cycle; keys_prev[idx] still updated (key not re-tried).

Structure
REQ-029 Package synth_pkg SHALL hold NUM_KEYS=13, NOTE_W=4, and the FSM state enum (IDLE, SCAN).
REQ-030 Combinational sub-module voice_pick SHALL take gate and age vectors and return free_found, free_idx (lowest free) and oldest_idx (max age, lowest index on tie).

Verification
REQ-031 Reset, keys_in=0x0001 -> within 4 cycles voice0 note=0, gate=1, trig pulse once; busy high 13 cycles.
REQ-032 keys 0x0001 then 0x0003 then 0x0001 -> voice1 note=1 gated, then voice1 gate=0, voice0 untouched.
REQ-033 NUM_VOICES=4, keys 0x001F simultaneously -> voices0..3 get notes 0..3; note 4: stealing build -> voice0 becomes note 4 with trig; non-stealing -> dropped pulses once.
REQ-034 keys toggle 0x0000->0x1000 during SCAN at idx=5 -> after SCAN ends, new scan assigns note 12; no missed/duplicate event.
REQ-035 Four keys held, ar pulsed low mid-SCAN -> all outputs 0 immediately; after release held keys reassigned to voices0..3 in ascending note order.
REQ-036 Release of a stolen note (note 0 after REQ-033 steal) -> no voice gate changes.
